// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a two-entry skid buffer for the 5-stage core.
// Control bundle is zeroed on every bubble; freeze and flush are handled in-stage.
module pipe_stage_elastic #(
    parameter int CTRL_W         = 8,
    parameter int DATA_W         = 128,
    parameter int FLUSH_CLR_DATA = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;

    assign in_ready_o  = (state_q != SKID) & ~stall_i & ~flush_i;
    assign out_valid_o = (state_q != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i & ~stall_i;
    assign ctrl_o      = ctrl_q;
    assign data_o      = data_q;
    assign occ_o       = state_q;

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            state_d     = EMPTY;
            ctrl_d      = '0;
            skid_ctrl_d = '0;
            if (FLUSH_CLR_DATA != 0) begin
                data_d      = '0;
                skid_data_d = '0;
            end
        end else if (!stall_i) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        ctrl_d  = ctrl_i;
                        data_d  = data_i;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        ctrl_d = ctrl_i;
                        data_d = data_i;
                    end else if (out_fire) begin
                        // Data is left in place; only control must read as a bubble.
                        state_d = EMPTY;
                        ctrl_d  = '0;
                    end else if (in_fire) begin
                        state_d     = SKID;
                        skid_ctrl_d = ctrl_i;
                        skid_data_d = data_i;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d     = FULL;
                        ctrl_d      = skid_ctrl_q;
                        data_d      = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic followed by a randomized run against a queue model.
module tb_pipe_stage_elastic;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, in_valid_i, out_ready_i;
    logic        in_ready_o, out_valid_o;
    logic [7:0]  ctrl_i, ctrl_o;
    logic [15:0] data_i, data_o;
    logic [1:0]  occ_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
    } item_t;
    item_t q[$];

    pipe_stage_elastic #(.CTRL_W(8), .DATA_W(16), .FLUSH_CLR_DATA(0)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .ctrl_i     (ctrl_i),
        .data_i     (data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .ctrl_o     (ctrl_o),
        .data_o     (data_o),
        .occ_o      (occ_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [15:0] d);
        in_valid_i = v;
        ctrl_i     = c;
        data_i     = d;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b0, 8'h00, 16'h0000);
        tick(); tick();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_occ", occ_o, 0);
        rst_i = 1'b0;

        // Single transfer, then drain to empty.
        out_ready_i = 1'b1;
        drive(1'b1, 8'h5A, 16'h1234);
        chk("first_ready", in_ready_o, 1);
        tick();
        chk("first_valid", out_valid_o, 1);
        chk("first_ctrl", ctrl_o, 8'h5A);
        chk("first_data", data_o, 16'h1234);
        chk("first_occ", occ_o, 1);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        chk("drain_valid", out_valid_o, 0);
        chk("drain_ctrl", ctrl_o, 0);
        chk("drain_data_hold", data_o, 16'h1234);
        chk("drain_occ", occ_o, 0);

        // Streaming: one item per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i + 1), 16'(16'h0100 + i));
            tick();
            chk("stream_valid", out_valid_o, 1);
            chk("stream_ctrl", ctrl_o, 8'(i + 1));
            chk("stream_data", data_o, 16'(16'h0100 + i));
            chk("stream_occ", occ_o, 1);
        end
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        chk("stream_end_valid", out_valid_o, 0);

        // Backpressure fills the skid entry.
        out_ready_i = 1'b0;
        drive(1'b1, 8'hA1, 16'hAAAA);
        tick();
        chk("bp_occ1", occ_o, 1);
        drive(1'b1, 8'hB2, 16'hBBBB);
        tick();
        chk("bp_occ2", occ_o, 2);
        chk("bp_ready", in_ready_o, 0);
        chk("bp_ctrlA", ctrl_o, 8'hA1);
        chk("bp_dataA", data_o, 16'hAAAA);
        drive(1'b0, 8'h00, 16'h0000);
        out_ready_i = 1'b1;
        tick();
        chk("bp_ctrlB", ctrl_o, 8'hB2);
        chk("bp_dataB", data_o, 16'hBBBB);
        chk("bp_occ_after", occ_o, 1);
        tick();
        chk("bp_empty", out_valid_o, 0);
        chk("bp_empty_occ", occ_o, 0);

        // Stall at occupancy 2.
        out_ready_i = 1'b0;
        drive(1'b1, 8'hC3, 16'hCCCC);
        tick();
        drive(1'b1, 8'hD4, 16'hDDDD);
        tick();
        stall_i = 1'b1; out_ready_i = 1'b1;
        drive(1'b1, 8'hEE, 16'hEEEE);
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", in_ready_o, 0);
            tick();
            chk("stall_occ", occ_o, 2);
            chk("stall_ctrl", ctrl_o, 8'hC3);
            chk("stall_data", data_o, 16'hCCCC);
        end
        stall_i = 1'b0;
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        chk("unstall_ctrl", ctrl_o, 8'hD4);
        chk("unstall_data", data_o, 16'hDDDD);
        chk("unstall_occ", occ_o, 1);
        tick();
        chk("unstall_empty", occ_o, 0);

        // Flush at occupancy 2 with stall and a pending input.
        out_ready_i = 1'b0;
        drive(1'b1, 8'h11, 16'h1111);
        tick();
        drive(1'b1, 8'h22, 16'h2222);
        tick();
        chk("pre_flush_occ", occ_o, 2);
        flush_i = 1'b1; stall_i = 1'b1;
        drive(1'b1, 8'h33, 16'h3333);
        chk("flush_ready", in_ready_o, 0);
        tick();
        flush_i = 1'b0; stall_i = 1'b0;
        drive(1'b0, 8'h00, 16'h0000);
        chk("flush_occ", occ_o, 0);
        chk("flush_valid", out_valid_o, 0);
        chk("flush_ctrl", ctrl_o, 0);
        chk("flush_data_hold", data_o, 16'h1111);
        out_ready_i = 1'b1;
        tick();
        chk("flush_no_ghost_occ", occ_o, 0);
        chk("flush_no_ghost_valid", out_valid_o, 0);

        // Asynchronous reset mid-cycle while full.
        out_ready_i = 1'b0;
        drive(1'b1, 8'h44, 16'h4444);
        tick();
        drive(1'b0, 8'h00, 16'h0000);
        chk("pre_rst_occ", occ_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_ctrl", ctrl_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_occ", occ_o, 0);
        #1 rst_i = 1'b0;
        out_ready_i = 1'b1;
        drive(1'b1, 8'h55, 16'h5555);
        tick();
        chk("post_rst_ctrl", ctrl_o, 8'h55);
        chk("post_rst_data", data_o, 16'h5555);
        chk("post_rst_occ", occ_o, 1);
        drive(1'b0, 8'h00, 16'h0000);
        tick();
        chk("post_rst_empty", occ_o, 0);

        // Randomized traffic against a reference queue.
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic inf, outf;
            item_t it;
            in_valid_i  = 1'($urandom_range(0, 1));
            ctrl_i      = 8'($urandom_range(1, 255));
            data_i      = 16'($urandom);
            out_ready_i = 1'($urandom_range(0, 1));
            stall_i     = ($urandom_range(0, 7) == 0);
            flush_i     = ($urandom_range(0, 31) == 0);
            #1;
            chk("rnd_ready", in_ready_o, 32'((q.size() < 2) && !stall_i && !flush_i));
            inf  = in_valid_i && (q.size() < 2) && !stall_i && !flush_i;
            outf = (q.size() > 0) && out_ready_i && !stall_i;
            it.c = ctrl_i;
            it.d = data_i;
            tick();
            if (flush_i) begin
                q.delete();
            end else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(it);
            end
            chk("rnd_occ", occ_o, q.size());
            chk("rnd_valid", out_valid_o, 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_ctrl", ctrl_o, q[0].c);
                chk("rnd_data", data_o, q[0].d);
            end else begin
                chk("rnd_bubble_ctrl", ctrl_o, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
